// File: rtl/ov7670_config_seq.sv
// rtl/ov7670_config_seq.sv - walks the OV7670 config ROM and issues SCCB register writes
module ov7670_config_seq #(
    parameter int DELAY_CYCLES = 250_000,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_dout,
    output logic              sccb_valid,
    input  logic              sccb_ready,
    output logic [7:0]        sccb_reg,
    output logic [7:0]        sccb_data,
    input  logic              sccb_done,
    output logic              busy,
    output logic              done
);

    localparam int                 CNT_W     = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = '1;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, SEND, WAIT, DELAY, NEXT, DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rom_addr   <= '0;
            sccb_valid <= 1'b0;
            sccb_reg   <= '0;
            sccb_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        rom_addr <= '0;
                        busy     <= 1'b1;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    if (rom_dout == 16'hFFFF) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (rom_dout == 16'hFFF0) begin
                        state <= DELAY;
                        cnt   <= '0;
                    end else begin
                        state      <= SEND;
                        sccb_reg   <= rom_dout[15:8];
                        sccb_data  <= rom_dout[7:0];
                        sccb_valid <= 1'b1;
                    end
                end
                SEND: begin
                    // Request is held until the master takes it; no timeout by design.
                    if (sccb_ready) begin
                        sccb_valid <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (sccb_done) state <= NEXT;
                end
                DELAY: begin
                    if (cnt == CNT_LAST) state <= NEXT;
                    else                 cnt   <= cnt + 1'b1;
                end
                NEXT: begin
                    // A ROM without a terminator stops at the last address rather than wrapping.
                    if (rom_addr == LAST_ADDR) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        rom_addr <= rom_addr + 1'b1;
                        state    <= FETCH;
                    end
                end
                DONE: begin
                    if (start) begin
                        state    <= FETCH;
                        rom_addr <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// tb/tb_ov7670_config_seq.sv - self-checking bench for ov7670_config_seq
module tb_ov7670_config_seq;
    localparam int D  = 20;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n, start, sccb_ready, sccb_done, sccb_valid, busy, done;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_dout;
    logic [7:0]    sccb_reg, sccb_data;

    ov7670_config_seq #(.DELAY_CYCLES(D), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .sccb_valid(sccb_valid), .sccb_ready(sccb_ready), .sccb_reg(sccb_reg),
        .sccb_data(sccb_data), .sccb_done(sccb_done), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [256];
    always @(posedge clk) rom_dout <= rom[rom_addr];

    int checks = 0, failures = 0;
    int cyc = 0, timer = 0, hold = 0, stab_err = 0, excl_err = 0;
    bit rand_ready = 0, rand_lat = 0, spur = 0;
    logic [15:0] acc_q [$];
    int          acc_cyc [$];
    logic [15:0] exp_q [$];
    int          exp_end;
    logic        p_valid = 0, p_acc = 0;
    logic [7:0]  p_reg = 0, p_data = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // SCCB master model and output monitor, all on the falling edge.
    initial begin
        sccb_ready = 1'b1;
        sccb_done  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            sccb_done = 1'b0;
            if (timer > 0) begin
                timer--;
                if (timer == 0) sccb_done = 1'b1;
            end else if (spur && $urandom_range(0, 7) == 0) begin
                sccb_done = 1'b1;
            end
            if (sccb_valid && hold > 0) begin
                sccb_ready = 1'b0;
                hold--;
            end else if (rand_ready) sccb_ready = 1'($urandom_range(0, 1));
            else sccb_ready = 1'b1;
            if (rst_n && p_valid && !p_acc &&
                !(sccb_valid && sccb_reg == p_reg && sccb_data == p_data)) stab_err++;
            if (busy && done) excl_err++;
            p_valid = sccb_valid;
            p_reg   = sccb_reg;
            p_data  = sccb_data;
            p_acc   = sccb_valid && sccb_ready && rst_n;
            if (p_acc) begin
                acc_q.push_back({sccb_reg, sccb_data});
                acc_cyc.push_back(cyc);
                timer = rand_lat ? $urandom_range(1, 6) : 5;
            end
        end
    end

    // Expected write list and final address, straight from the ROM rules.
    task automatic model();
        exp_q.delete();
        exp_end = 255;
        for (int i = 0; i < 256; i++) begin
            if (rom[i] == 16'hFFFF) begin
                exp_end = i;
                break;
            end
            if (rom[i] != 16'hFFF0) exp_q.push_back(rom[i]);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input bit spam);
        int n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (!done && spam && busy && (n % 3 == 0)) start = 1'b1;
        end
        start = 1'b0;
        chk("done_timeout", done, 1'b1);
    endtask

    task automatic check_run(input string tag);
        model();
        chk({tag, "_nwrites"}, acc_q.size(), exp_q.size());
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
            if (acc_q[i] !== exp_q[i]) chk({tag, "_write"}, acc_q[i], exp_q[i]);
        chk({tag, "_addr"}, rom_addr, exp_end);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_stable"}, stab_err, 0);
        chk({tag, "_excl"}, excl_err, 0);
    endtask

    task automatic load_basic();
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1204; rom[3] = 16'hFFFF;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        load_basic();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_addr", rom_addr, 0);
        chk("rst_valid", sccb_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_regdata", {sccb_reg, sccb_data}, 0);

        // Basic sequence with start-to-valid latency.
        acc_q.delete(); acc_cyc.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("lat_busy_t1", busy, 1'b1);
        chk("lat_valid_t1", sccb_valid, 1'b0);
        @(negedge clk);
        chk("lat_valid_t2", sccb_valid, 1'b0);
        @(negedge clk);
        chk("lat_valid_t3", sccb_valid, 1'b1);
        chk("lat_regdata", {sccb_reg, sccb_data}, 16'h1280);
        wait_done(0);
        check_run("basic");
        if (acc_cyc.size() >= 2) chk("delay_gap", (acc_cyc[1] - acc_cyc[0]) >= D, 1'b1);

        // Master stalls the first request for 20 cycles.
        rom[0] = 16'h1280; rom[1] = 16'hFFFF;
        acc_q.delete();
        hold = 20;
        pulse_start();
        wait_done(0);
        chk("stall_hold_used", hold, 0);
        check_run("stall");

        // start pulses while busy must not disturb the walk.
        load_basic();
        acc_q.delete();
        pulse_start();
        wait_done(1);
        check_run("spam");

        // Reset mid-DELAY, then replay from address 0.
        acc_q.delete();
        pulse_start();
        for (int n = 0; n < 200 && acc_q.size() == 0; n++) @(negedge clk);
        repeat (12) @(negedge clk);
        chk("mid_delay_busy", busy, 1'b1);
        chk("mid_delay_addr", rom_addr, 1);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        chk("mrst_addr", rom_addr, 0);
        chk("mrst_busy_done", {busy, done}, 2'b00);
        chk("mrst_valid", sccb_valid, 1'b0);
        acc_q.delete();
        pulse_start();
        wait_done(0);
        check_run("replay");

        // Randomized ROMs with random handshake timing and stray done pulses.
        rand_ready = 1; rand_lat = 1; spur = 1;
        for (int it = 0; it < 4; it++) begin
            int len = $urandom_range(3, 30);
            for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 5))
                    0:       rom[i] = 16'hFFF0;
                    1:       rom[i] = 16'h0000;
                    default: rom[i] = {8'($urandom_range(0, 8'hFE)), 8'($urandom)};
                endcase
            end
            rom[len] = 16'hFFFF;
            acc_q.delete();
            pulse_start();
            wait_done(it[0]);
            check_run("rand");
        end

        // No terminator: full ROM walk, stop at the last address.
        for (int i = 0; i < 256; i++) rom[i] = 16'h3A04;
        acc_q.delete();
        pulse_start();
        wait_done(0);
        check_run("full");
        repeat (3) @(negedge clk);
        chk("full_hold_addr", rom_addr, 255);
        chk("full_hold_done", done, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
